// File: rtl/td4_pkg.sv
// Shared encodings and instruction geometry for the TD4 core and its execution controller.
package td4_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned IMM_W     = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned ROM_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_LOAD = 2'b11
  } exec_state_e;

endpackage

// File: rtl/td4_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while not cleared, tick flags the last count.
module td4_prescaler #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: run/step/halt/breakpoint sequencing via a single cpu_en pulse,
// and program-memory write port used while the core is held in reset.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run_req,
  input  logic                    step_req,
  input  logic                    halt_req,
  input  logic                    load_req,
  input  logic                    bp_en,
  input  logic [ADDR_W-1:0]       bp_addr,
  input  logic [ADDR_W-1:0]       ip,
  input  logic                    load_valid,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [OP_W+IMM_W-1:0]   load_data,
  output logic                    load_ready,
  output logic                    cpu_en,
  output logic                    cpu_rst_n,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [OP_W+IMM_W-1:0]   mem_wdata,
  output logic [1:0]              state,
  output logic                    bp_hit
);

  exec_state_e state_q, state_d;
  logic run_q, step_q, run_rise, step_rise;
  logic tick, bp_match, load_acc;
  logic cpu_en_q, cpu_en_d;
  logic cpu_rst_n_q;
  logic bp_hit_q, bp_hit_d;
  logic skip_bp_q, skip_bp_d;
  logic mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [OP_W+IMM_W-1:0] mem_wdata_q;

  assign run_rise  = run_req & ~run_q;
  assign step_rise = step_req & ~step_q;
  // skip_bp lets a run resumed at the breakpoint address execute its first instruction.
  assign bp_match  = bp_en & (ip == bp_addr) & ~skip_bp_q;
  assign load_acc  = (state_q == ST_LOAD) & load_valid;

  td4_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (state_q != ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    cpu_en_d  = 1'b0;
    bp_hit_d  = bp_hit_q;
    skip_bp_d = skip_bp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (load_req) begin
          state_d = ST_LOAD;
        end else if (step_rise) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end else if (run_rise) begin
          state_d   = ST_RUN;
          bp_hit_d  = 1'b0;
          skip_bp_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (load_req) begin
          state_d = ST_LOAD;
        end else if (tick) begin
          if (bp_match) begin
            bp_hit_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cpu_en_d  = 1'b1;
            skip_bp_d = 1'b0;
          end
        end
      end
      // The single step pulse is already on cpu_en during this state.
      ST_STEP: begin
        state_d = (load_req && !halt_req) ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        if (halt_req || !load_req) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      skip_bp_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_req;
      step_q      <= step_req;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_n_q <= (state_d != ST_LOAD);
      bp_hit_q    <= bp_hit_d;
      skip_bp_q   <= skip_bp_d;
      mem_we_q    <= load_acc;
      if (load_acc) begin
        mem_addr_q  <= load_addr;
        mem_wdata_q <= load_data;
      end
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign cpu_en     = cpu_en_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign state      = state_q;
  assign bp_hit     = bp_hit_q;

endmodule
